// File: rtl/ika2151_timer_pkg.sv
// Shared widths and terminal counts for the IKA2151 Timer A / Timer B block.
package ika2151_timer_pkg;
  localparam int TMRA_W  = 10;
  localparam int TMRB_W  = 8;
  localparam int PRESC_W = 4;

  localparam logic [TMRA_W-1:0]  TMRA_TC  = 10'd1023;
  localparam logic [TMRB_W-1:0]  TMRB_TC  = 8'd255;
  localparam logic [PRESC_W-1:0] PRESC_TC = 4'd15;
endpackage

// File: rtl/ika2151_timer_cntr.sv
// Up-counter with preload: loads while stopped, reloads at terminal count instead of wrapping.
module ika2151_timer_cntr #(
  parameter int           W  = 10,
  parameter logic [W-1:0] TC = '1
) (
  input  logic         i_EMUCLK,
  input  logic         i_MRST_n,
  input  logic         i_step,
  input  logic         i_run,
  input  logic [W-1:0] i_preload,
  output logic [W-1:0] o_cnt,
  output logic         o_ovfl
);
  logic [W-1:0] cnt;
  logic         at_tc;

  assign at_tc  = (cnt == TC);
  // Overflow is an event of the stepping tick itself; the top registers it.
  assign o_ovfl = i_step & i_run & at_tc;
  assign o_cnt  = cnt;

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      cnt <= '0;
    end else if (i_step) begin
      if (!i_run || at_tc) cnt <= i_preload;
      else                 cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ika2151_timer.sv
// IKA2151 timers: Timer A, prescaled Timer B, status flags and the shared IRQ line.
module ika2151_timer
  import ika2151_timer_pkg::*;
(
  input  logic               i_EMUCLK,
  input  logic               i_MRST_n,
  input  logic               i_phi1_NCEN_n,
  input  logic               i_CYCLE_31,
  input  logic [9:0]         i_CLKA,
  input  logic [7:0]         i_CLKB,
  input  logic               i_LOAD_A,
  input  logic               i_LOAD_B,
  input  logic               i_IRQEN_A,
  input  logic               i_IRQEN_B,
  input  logic               i_FRST_A,
  input  logic               i_FRST_B,
  output logic               o_TIMERA_OVFL,
  output logic               o_FLAG_A,
  output logic               o_FLAG_B,
  output logic               o_IRQ_n,
  output logic [TMRA_W-1:0]  o_DBG_CNTA,
  output logic [TMRB_W-1:0]  o_DBG_CNTB,
  output logic [PRESC_W-1:0] o_DBG_PRESC
);
  logic               phi1_en;
  logic               tick;
  logic               step_b;
  logic [PRESC_W-1:0] presc;
  logic [TMRA_W-1:0]  cnt_a;
  logic [TMRB_W-1:0]  cnt_b;
  logic               ovf_a;
  logic               ovf_b;
  logic               ovfl_a_q;
  logic               flag_a;
  logic               flag_b;
  logic               irq_n_q;

  assign phi1_en = ~i_phi1_NCEN_n;
  assign tick    = phi1_en & i_CYCLE_31;
  // Timer B advances once per full prescaler revolution (every 16th tick).
  assign step_b  = tick & (presc == PRESC_TC);

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n)  presc <= '0;
    else if (tick)  presc <= presc + 1'b1;
  end

  ika2151_timer_cntr #(.W(TMRA_W), .TC(TMRA_TC)) u_cntr_a (
    .i_EMUCLK  (i_EMUCLK),
    .i_MRST_n  (i_MRST_n),
    .i_step    (tick),
    .i_run     (i_LOAD_A),
    .i_preload (i_CLKA),
    .o_cnt     (cnt_a),
    .o_ovfl    (ovf_a)
  );

  ika2151_timer_cntr #(.W(TMRB_W), .TC(TMRB_TC)) u_cntr_b (
    .i_EMUCLK  (i_EMUCLK),
    .i_MRST_n  (i_MRST_n),
    .i_step    (step_b),
    .i_run     (i_LOAD_B),
    .i_preload (i_CLKB),
    .o_cnt     (cnt_b),
    .o_ovfl    (ovf_b)
  );

  // A flag set in the same enable as its reset strobe wins; IRQ lags flags by one enable.
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      ovfl_a_q <= 1'b0;
      flag_a   <= 1'b0;
      flag_b   <= 1'b0;
      irq_n_q  <= 1'b1;
    end else if (phi1_en) begin
      ovfl_a_q <= ovf_a;
      flag_a   <= (ovf_a & i_IRQEN_A) | (flag_a & ~i_FRST_A);
      flag_b   <= (ovf_b & i_IRQEN_B) | (flag_b & ~i_FRST_B);
      irq_n_q  <= ~(flag_a | flag_b);
    end
  end

  assign o_TIMERA_OVFL = ovfl_a_q;
  assign o_FLAG_A      = flag_a;
  assign o_FLAG_B      = flag_b;
  assign o_IRQ_n       = irq_n_q;
  assign o_DBG_CNTA    = cnt_a;
  assign o_DBG_CNTB    = cnt_b;
  assign o_DBG_PRESC   = presc;
endmodule

// File: tb/tb_ika2151_timer.sv
// Directed bench for ika2151_timer: phi1 enable every other clock, tick every 32 enables.
module tb_ika2151_timer;
  logic       i_EMUCLK;
  logic       i_MRST_n;
  logic       i_phi1_NCEN_n;
  logic       i_CYCLE_31;
  logic [9:0] i_CLKA;
  logic [7:0] i_CLKB;
  logic       i_LOAD_A, i_LOAD_B, i_IRQEN_A, i_IRQEN_B, i_FRST_A, i_FRST_B;
  logic       o_TIMERA_OVFL, o_FLAG_A, o_FLAG_B, o_IRQ_n;
  logic [9:0] o_DBG_CNTA;
  logic [7:0] o_DBG_CNTB;
  logic [3:0] o_DBG_PRESC;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;
  int slot     = 0;
  logic [9:0] exp_q[$];

  ika2151_timer dut (
    .i_EMUCLK(i_EMUCLK), .i_MRST_n(i_MRST_n), .i_phi1_NCEN_n(i_phi1_NCEN_n),
    .i_CYCLE_31(i_CYCLE_31), .i_CLKA(i_CLKA), .i_CLKB(i_CLKB),
    .i_LOAD_A(i_LOAD_A), .i_LOAD_B(i_LOAD_B), .i_IRQEN_A(i_IRQEN_A),
    .i_IRQEN_B(i_IRQEN_B), .i_FRST_A(i_FRST_A), .i_FRST_B(i_FRST_B),
    .o_TIMERA_OVFL(o_TIMERA_OVFL), .o_FLAG_A(o_FLAG_A), .o_FLAG_B(o_FLAG_B),
    .o_IRQ_n(o_IRQ_n), .o_DBG_CNTA(o_DBG_CNTA), .o_DBG_CNTB(o_DBG_CNTB),
    .o_DBG_PRESC(o_DBG_PRESC)
  );

  // clock / reset
  initial begin
    i_EMUCLK = 1'b0;
    forever #5 i_EMUCLK = ~i_EMUCLK;
  end

  // phi1 enable generator: slot strobe held across the enable and the clock after it
  initial begin
    i_phi1_NCEN_n = 1'b1;
    i_CYCLE_31    = 1'b0;
    forever begin
      @(negedge i_EMUCLK);
      i_phi1_NCEN_n = ~i_phi1_NCEN_n;
      if (!i_phi1_NCEN_n) begin
        i_CYCLE_31 = (slot == 31);
        slot = (slot + 1) % 32;
      end
    end
  end

  // independent tick count since reset release (prescaler phase model)
  initial begin
    forever begin
      @(posedge i_EMUCLK);
      if (!i_MRST_n) tick_cnt = 0;
      else if (!i_phi1_NCEN_n && i_CYCLE_31) tick_cnt = tick_cnt + 1;
    end
  end

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge i_EMUCLK);
      if (!i_phi1_NCEN_n && i_CYCLE_31) begin seen = 1'b1; break; end
    end
    #1;
    if (!seen) begin n_fail++; $display("FAIL tick_timeout: got no tick, required one within 80 clocks"); end
  endtask

  task automatic next_enable();
    repeat (2) @(posedge i_EMUCLK);
    #1;
  endtask

  task automatic test_reset();
    #23;
    n_checks++; if (o_TIMERA_OVFL !== 1'b0) begin n_fail++; $display("FAIL rst_ovfl: got %b required 0", o_TIMERA_OVFL); end
    n_checks++; if (o_FLAG_A !== 1'b0) begin n_fail++; $display("FAIL rst_flag_a: got %b required 0", o_FLAG_A); end
    n_checks++; if (o_FLAG_B !== 1'b0) begin n_fail++; $display("FAIL rst_flag_b: got %b required 0", o_FLAG_B); end
    n_checks++; if (o_IRQ_n !== 1'b1) begin n_fail++; $display("FAIL rst_irq_n: got %b required 1", o_IRQ_n); end
    n_checks++; if (o_DBG_CNTA !== 10'd0) begin n_fail++; $display("FAIL rst_cnt_a: got %0d required 0", o_DBG_CNTA); end
    n_checks++; if (o_DBG_PRESC !== 4'd0) begin n_fail++; $display("FAIL rst_presc: got %0d required 0", o_DBG_PRESC); end
    @(negedge i_EMUCLK);
    i_MRST_n = 1'b1;
  endtask

  task automatic test_timer_a_fast();
    i_CLKA = 10'd1022; i_IRQEN_A = 1'b1; i_LOAD_A = 1'b0;
    wait_tick();
    n_checks++; if (o_DBG_CNTA !== 10'd1022) begin n_fail++; $display("FAIL a_preload: got %0d required 1022", o_DBG_CNTA); end
    i_LOAD_A = 1'b1;
    wait_tick();
    n_checks++; if (o_DBG_CNTA !== 10'd1023) begin n_fail++; $display("FAIL a_tick1_cnt: got %0d required 1023", o_DBG_CNTA); end
    n_checks++; if (o_TIMERA_OVFL !== 1'b0) begin n_fail++; $display("FAIL a_tick1_ovfl: got %b required 0", o_TIMERA_OVFL); end
    wait_tick();
    n_checks++; if (o_TIMERA_OVFL !== 1'b1) begin n_fail++; $display("FAIL a_tick2_ovfl: got %b required 1", o_TIMERA_OVFL); end
    n_checks++; if (o_FLAG_A !== 1'b1) begin n_fail++; $display("FAIL a_tick2_flag: got %b required 1", o_FLAG_A); end
    n_checks++; if (o_IRQ_n !== 1'b1) begin n_fail++; $display("FAIL a_irq_latency: got %b required 1", o_IRQ_n); end
    n_checks++; if (o_DBG_CNTA !== 10'd1022) begin n_fail++; $display("FAIL a_reload: got %0d required 1022", o_DBG_CNTA); end
    next_enable();
    n_checks++; if (o_IRQ_n !== 1'b0) begin n_fail++; $display("FAIL a_irq_asserted: got %b required 0", o_IRQ_n); end
    n_checks++; if (o_TIMERA_OVFL !== 1'b0) begin n_fail++; $display("FAIL a_ovfl_width: got %b required 0", o_TIMERA_OVFL); end
    wait_tick();
    n_checks++; if (o_TIMERA_OVFL !== 1'b0) begin n_fail++; $display("FAIL a_tick3_ovfl: got %b required 0", o_TIMERA_OVFL); end
    wait_tick();
    n_checks++; if (o_TIMERA_OVFL !== 1'b1) begin n_fail++; $display("FAIL a_tick4_ovfl: got %b required 1", o_TIMERA_OVFL); end
    i_LOAD_A = 1'b0; i_IRQEN_A = 1'b0; i_FRST_A = 1'b1;
    wait_tick();
    i_FRST_A = 1'b0;
    n_checks++; if (o_FLAG_A !== 1'b0) begin n_fail++; $display("FAIL a_frst_clear: got %b required 0", o_FLAG_A); end
    next_enable();
    n_checks++; if (o_IRQ_n !== 1'b1) begin n_fail++; $display("FAIL a_irq_release: got %b required 1", o_IRQ_n); end
  endtask

  task automatic test_timer_b();
    i_CLKB = 8'd254; i_IRQEN_B = 1'b1; i_LOAD_B = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_tick();
      if (tick_cnt % 16 == 0) break;
    end
    n_checks++; if (o_DBG_CNTB !== 8'd254) begin n_fail++; $display("FAIL b_preload: got %0d required 254", o_DBG_CNTB); end
    n_checks++; if (o_DBG_PRESC !== 4'd0) begin n_fail++; $display("FAIL b_presc_wrap: got %0d required 0", o_DBG_PRESC); end
    i_LOAD_B = 1'b1;
    for (int t = 1; t <= 32; t++) begin
      wait_tick();
      if (t == 16) begin
        n_checks++; if (o_DBG_CNTB !== 8'd255) begin n_fail++; $display("FAIL b_step16: got %0d required 255", o_DBG_CNTB); end
      end
      if (t == 31) begin
        n_checks++; if (o_FLAG_B !== 1'b0) begin n_fail++; $display("FAIL b_flag_tick31: got %b required 0", o_FLAG_B); end
      end
      if (t == 32) begin
        n_checks++; if (o_FLAG_B !== 1'b1) begin n_fail++; $display("FAIL b_flag_tick32: got %b required 1", o_FLAG_B); end
        n_checks++; if (o_DBG_CNTB !== 8'd254) begin n_fail++; $display("FAIL b_reload: got %0d required 254", o_DBG_CNTB); end
      end
    end
    i_LOAD_B = 1'b0; i_IRQEN_B = 1'b0;
    next_enable();
    n_checks++; if (o_FLAG_B !== 1'b1) begin n_fail++; $display("FAIL b_flag_kept_irqen0: got %b required 1", o_FLAG_B); end
    i_FRST_B = 1'b1;
    wait_tick();
    i_FRST_B = 1'b0;
    n_checks++; if (o_FLAG_B !== 1'b0) begin n_fail++; $display("FAIL b_frst_clear: got %b required 0", o_FLAG_B); end
    next_enable();
  endtask

  task automatic test_irq_disabled();
    i_CLKA = 10'd1023; i_IRQEN_A = 1'b0; i_LOAD_A = 1'b0;
    wait_tick();
    i_LOAD_A = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_tick();
      n_checks++; if (o_TIMERA_OVFL !== 1'b1) begin n_fail++; $display("FAIL dis_ovfl[%0d]: got %b required 1", t, o_TIMERA_OVFL); end
      n_checks++; if (o_FLAG_A !== 1'b0) begin n_fail++; $display("FAIL dis_flag[%0d]: got %b required 0", t, o_FLAG_A); end
      n_checks++; if (o_IRQ_n !== 1'b1) begin n_fail++; $display("FAIL dis_irq_n[%0d]: got %b required 1", t, o_IRQ_n); end
    end
    next_enable();
    n_checks++; if (o_TIMERA_OVFL !== 1'b0) begin n_fail++; $display("FAIL dis_ovfl_low: got %b required 0", o_TIMERA_OVFL); end
    i_LOAD_A = 1'b0;
    wait_tick();
  endtask

  task automatic test_flag_set_wins();
    i_CLKA = 10'd1022; i_IRQEN_A = 1'b1; i_LOAD_A = 1'b0;
    wait_tick();
    i_LOAD_A = 1'b1;
    wait_tick();
    i_FRST_A = 1'b1;
    wait_tick();
    i_FRST_A = 1'b0;
    n_checks++; if (o_FLAG_A !== 1'b1) begin n_fail++; $display("FAIL sw_set_wins: got %b required 1", o_FLAG_A); end
    next_enable();
    n_checks++; if (o_FLAG_A !== 1'b1) begin n_fail++; $display("FAIL sw_flag_hold: got %b required 1", o_FLAG_A); end
    i_FRST_A = 1'b1;
    next_enable();
    i_FRST_A = 1'b0;
    n_checks++; if (o_FLAG_A !== 1'b0) begin n_fail++; $display("FAIL sw_later_clear: got %b required 0", o_FLAG_A); end
    i_LOAD_A = 1'b0; i_IRQEN_A = 1'b0;
    wait_tick();
  endtask

  task automatic test_clk_change();
    i_CLKA = 10'd1020; i_LOAD_A = 1'b0;
    wait_tick();
    i_LOAD_A = 1'b1;
    wait_tick();
    i_CLKA = 10'd1000;
    exp_q.push_back(10'd1022); exp_q.push_back(10'd1023);
    exp_q.push_back(10'd1000); exp_q.push_back(10'd1001);
    while (exp_q.size() > 0) begin
      logic [9:0] exp_cnt;
      exp_cnt = exp_q.pop_front();
      wait_tick();
      n_checks++; if (o_DBG_CNTA !== exp_cnt) begin n_fail++; $display("FAIL clk_change_cnt: got %0d required %0d", o_DBG_CNTA, exp_cnt); end
    end
    i_LOAD_A = 1'b0;
    wait_tick();
  endtask

  task automatic test_reset_mid();
    i_CLKA = 10'd690; i_LOAD_A = 1'b0;
    wait_tick();
    i_LOAD_A = 1'b1;
    repeat (10) wait_tick();
    n_checks++; if (o_DBG_CNTA !== 10'd700) begin n_fail++; $display("FAIL rm_cnt700: got %0d required 700", o_DBG_CNTA); end
    #2;
    i_MRST_n = 1'b0;
    #1;
    n_checks++; if (o_DBG_CNTA !== 10'd0) begin n_fail++; $display("FAIL rm_cnt_async: got %0d required 0", o_DBG_CNTA); end
    n_checks++; if (o_DBG_PRESC !== 4'd0) begin n_fail++; $display("FAIL rm_presc_async: got %0d required 0", o_DBG_PRESC); end
    n_checks++; if (o_TIMERA_OVFL !== 1'b0) begin n_fail++; $display("FAIL rm_ovfl_async: got %b required 0", o_TIMERA_OVFL); end
    n_checks++; if (o_IRQ_n !== 1'b1) begin n_fail++; $display("FAIL rm_irq_async: got %b required 1", o_IRQ_n); end
    i_LOAD_A = 1'b0;
    repeat (3) @(negedge i_EMUCLK);
    i_MRST_n = 1'b1;
    wait_tick();
    n_checks++; if (o_DBG_CNTA !== 10'd690) begin n_fail++; $display("FAIL rm_restart: got %0d required 690", o_DBG_CNTA); end
    n_checks++; if (o_DBG_PRESC !== 4'd1) begin n_fail++; $display("FAIL rm_presc_first: got %0d required 1", o_DBG_PRESC); end
    i_LOAD_A = 1'b1;
    wait_tick();
    n_checks++; if (o_DBG_CNTA !== 10'd691) begin n_fail++; $display("FAIL rm_count_on: got %0d required 691", o_DBG_CNTA); end
    i_LOAD_A = 1'b0;
    wait_tick();
  endtask

  task automatic test_load_restart();
    i_CLKA = 10'd890; i_LOAD_A = 1'b0;
    wait_tick();
    i_LOAD_A = 1'b1;
    repeat (10) wait_tick();
    n_checks++; if (o_DBG_CNTA !== 10'd900) begin n_fail++; $display("FAIL lr_cnt900: got %0d required 900", o_DBG_CNTA); end
    i_LOAD_A = 1'b0;
    wait_tick();
    n_checks++; if (o_DBG_CNTA !== 10'd890) begin n_fail++; $display("FAIL lr_stop_preload: got %0d required 890", o_DBG_CNTA); end
    i_CLKA = 10'd880;
    wait_tick();
    n_checks++; if (o_DBG_CNTA !== 10'd880) begin n_fail++; $display("FAIL lr_stopped_follow: got %0d required 880", o_DBG_CNTA); end
    i_LOAD_A = 1'b1;
    wait_tick();
    n_checks++; if (o_DBG_CNTA !== 10'd881) begin n_fail++; $display("FAIL lr_resume: got %0d required 881", o_DBG_CNTA); end
    i_LOAD_A = 1'b0;
  endtask

  initial begin
    i_MRST_n  = 1'b0;
    i_CLKA    = 10'd0;
    i_CLKB    = 8'd0;
    i_LOAD_A  = 1'b0; i_LOAD_B  = 1'b0;
    i_IRQEN_A = 1'b0; i_IRQEN_B = 1'b0;
    i_FRST_A  = 1'b0; i_FRST_B  = 1'b0;
    test_reset();
    test_timer_a_fast();
    test_timer_b();
    test_irq_disabled();
    test_flag_set_wins();
    test_clk_change();
    test_reset_mid();
    test_load_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ika2151_timer.md
IKA2151_TIMER -- requirements
Module: IKA2151_timer

Interface
REQ-001 SHALL have port i_EMUCLK, input, 1: emulator master clock; the only clock.
REQ-002 SHALL have port i_MRST_n, input, 1: asynchronous, active-low reset; driven from the core internal reset.
REQ-003 SHALL have port i_phi1_NCEN_n, input, 1: phi1 negative-edge clock enable; all state updates are qualified by it being low.
REQ-004 SHALL have port i_CYCLE_31, input, 1: sample-slot strobe, high during one phi1 enable period of every 32.
REQ-005 SHALL have port i_CLKA, input, 10: Timer A preload value.
REQ-006 SHALL have port i_CLKB, input, 8: Timer B preload value.
REQ-007 SHALL have ports i_LOAD_A, i_LOAD_B, i_IRQEN_A and i_IRQEN_B, input, 1 each: run and IRQ-enable bits for each timer.
REQ-008 SHALL have ports i_FRST_A and i_FRST_B, input, 1 each: flag-reset strobes.
REQ-009 SHALL have port o_TIMERA_OVFL, output, 1: Timer A overflow pulse, used for CSM key-on.
REQ-010 SHALL have ports o_FLAG_A and o_FLAG_B, output, 1 each: status flags.
REQ-011 SHALL have port o_IRQ_n, output, 1: active-low interrupt request.

Function
REQ-012 SHALL define tick = (~i_phi1_NCEN_n & i_CYCLE_31), occurring once per 32 phi1 cycles.
REQ-013 On a tick with i_LOAD_A=0, cntA SHALL be loaded with i_CLKA, and it SHALL hold i_CLKA while stopped.
REQ-014 On a tick with i_LOAD_A=1, cntA SHALL increment, except when cntA=1023, where it SHALL reload i_CLKA and raise the overflow event; wrap to 0 is forbidden.
REQ-015 Prescaler SHALL be a 4-bit free-running counter that increments on every tick and wraps from 15 to 0, independent of the LOAD bits.
REQ-016 Timer B SHALL step only on a tick where prescaler=15, using the same load/increment/reload rules as REQ-013/014 with an 8-bit width and 255 as the terminal count.
REQ-017 Timer A period SHALL be (1024-CLKA) ticks, and Timer B period SHALL be 16*(256-CLKB) ticks.
REQ-018 o_TIMERA_OVFL SHALL be registered, high for exactly one phi1 enable period after the overflow tick, and independent of i_IRQEN_A.
REQ-019 FLAG_x SHALL set on an overflow of timer x when i_IRQEN_x=1, and SHALL NOT set on an overflow while i_IRQEN_x=0.
REQ-020 FLAG_x SHALL clear on any phi1 enable where i_FRST_x=1.
REQ-021 If a flag set and its flag reset occur in the same enable, set SHALL win.
REQ-022 Clearing i_IRQEN_x SHALL NOT clear a flag that is already set.
REQ-023 o_IRQ_n SHALL equal ~(FLAG_A | FLAG_B), registered, with one phi1 enable of latency after the flag update.
REQ-024 A change of i_CLKA or i_CLKB while running SHALL take effect only at the next reload.
REQ-025 Clearing i_LOAD_x mid-count SHALL stop counting and preload i_CLKx on the next step.
REQ-026 Setting i_LOAD_x again SHALL restart counting from i_CLKx.

Reset
REQ-027 While i_MRST_n=0, cntA, cntB and the prescaler SHALL be 0.
REQ-028 While i_MRST_n=0, FLAG_A, FLAG_B and o_TIMERA_OVFL SHALL be 0, and o_IRQ_n SHALL be 1.
REQ-029 Reset SHALL take effect immediately without a clock; after release, the first update SHALL occur on the next phi1 enable.
REQ-030 An assertion of reset mid-count SHALL discard the partial count and any pending overflow pulse.

Structure
REQ-031 A shared package SHALL hold TMRA_W=10, TMRB_W=8, PRESC_W=4, and the terminal counts 1023 and 255.
REQ-032 The block SHALL instantiate one parameterized sub-module, IKA2151_timer_cntr, twice.
REQ-033 IKA2151_timer_cntr SHALL take a width parameter and the inputs step, run and preload, and SHALL produce the count and the overflow event.
REQ-034 The prescaler, flags and IRQ logic SHALL remain in the top module.

Verification
REQ-035 Bench SHALL drive CLKA=1022 and LOAD_A=1 with IRQEN_A=1, and SHALL check that OVFL pulses on the 2nd tick, FLAG_A=1, o_IRQ_n=0, and the 2nd OVFL follows 2 ticks later.
REQ-036 Bench SHALL drive CLKB=254 and LOAD_B=1 with IRQEN_B=1, and SHALL check that FLAG_B sets after 32 ticks and not at tick 31.
REQ-037 Bench SHALL drive IRQEN_A=0 with CLKA=1023, and SHALL check that OVFL pulses every tick while FLAG_A stays 0 and o_IRQ_n stays 1.
REQ-038 Bench SHALL drive FRST_A in the same enable as an A overflow, and SHALL check that FLAG_A stays 1; a FRST_A on a later enable SHALL clear FLAG_A.
REQ-039 Bench SHALL assert i_MRST_n=0 with cntA=700, and SHALL check that all outputs take their reset values asynchronously and that the count restarts from CLKA after release.
REQ-040 Bench SHALL set LOAD_A=0 at cntA=900 and then set LOAD_A=1, and SHALL check that the count resumes from CLKA, not 900.
